finalsoc_key_irq: RTL and testbench
===================================

FINALSOC_KEY_IRQ -- requirements
Module: finalsoc_key_irq

Interface
REQ-001 Parameter: WIDTH, default 2, number of input bits (1..32).
REQ-002 Parameter: DEBOUNCE_CYCLES, default 16, consecutive stable clocks required to accept a new level (2..65535).
REQ-003 Parameter: EDGE_MODE, default 1, capture edge: 0 rising, 1 falling, 2 either.
REQ-004 Parameter: IDLE_LEVEL, default 1, released-key level, replicated across WIDTH.
REQ-005 Port: clk  input  1  single clock for all logic.
REQ-006 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-007 Port: address  input  2  Avalon-MM word address.
REQ-008 Port: chipselect  input  1  Avalon-MM slave select.
REQ-009 Port: write_n  input  1  Avalon-MM write strobe, active-low, qualified by chipselect.
REQ-010 Port: writedata  input  32  Avalon-MM write data.
REQ-011 Port: in_port  input  WIDTH  raw, asynchronous key inputs.
REQ-012 Port: readdata  output  32  registered Avalon-MM read data.
REQ-013 Port: irq  output  1  level interrupt, active-high.

Function
REQ-014 in_port SHALL pass through a two-flop synchronizer per bit before any other use.
REQ-015 With debounce compiled in, each bit SHALL keep a counter that clears whenever synchronized value equals stable value and increments otherwise; stable SHALL take the synchronized value, with counter cleared, on the clock the counter reaches DEBOUNCE_CYCLES-1.
REQ-016 A glitch shorter than DEBOUNCE_CYCLES clocks at the synchronizer output SHALL NOT change stable.
REQ-017 Edge detect SHALL compare stable with a one-clock-delayed copy; a qualifying edge per EDGE_MODE SHALL set the corresponding edgecapture bit on the following clock.
REQ-018 Register map: address 0 data (stable, read-only); 1 reserved (reads 0, writes ignored); 2 irqmask (RW, WIDTH bits); 3 edgecapture (read; write-1-to-clear per bit).
REQ-019 Write SHALL occur on the clock where chipselect=1 and write_n=0; writes to address 0 or 1 SHALL have no effect.
REQ-020 readdata SHALL register the addressed register, zero-extended to 32 bits, every clock; read latency exactly 1 clock; chipselect does not gate readdata.
REQ-021 Same-clock edge and write-1-clear on one edgecapture bit: the bit SHALL remain 1 (set wins).
REQ-022 irq SHALL equal OR of (edgecapture AND irqmask), from registered state only, no combinational path from bus inputs.
REQ-023 Edges SHALL be captured regardless of irqmask; unmasking a set bit SHALL assert irq on the next clock.

Reset
REQ-024 On reset_n low, asynchronously: synchronizer flops, stable and delayed copy to IDLE_LEVEL; debounce counters, irqmask, edgecapture, readdata to 0; irq to 0.
REQ-025 Release of reset SHALL NOT generate a spurious edge when in_port is at IDLE_LEVEL.
REQ-026 Reset asserted mid-debounce SHALL discard the partial count; counting restarts from 0 after release.

Configuration
REQ-027 Macro FINALSOC_KEY_DEBOUNCE_EN defined: debounce counters present per REQ-015/016.
REQ-028 Macro FINALSOC_KEY_DEBOUNCE_EN undefined: no counters; stable SHALL equal the synchronizer output registered once; DEBOUNCE_CYCLES ignored; register map and edge/irq behaviour unchanged.

Verification
REQ-029 Reset, WIDTH=2, in_port=2'b11, read address 0 -> readdata=0x3 one clock after address; irq=0; edgecapture=0.
REQ-030 Debounce on, DEBOUNCE_CYCLES=16: in_port[0] low for 10 clocks then high -> data stays 0x3, edgecapture stays 0; low held 40 clocks -> data=0x2, edgecapture=0x1.
REQ-031 irqmask=0x1 written, falling edge on bit 0 -> irq=1; write 0x1 to address 3 -> edgecapture=0, irq=0 next clock.
REQ-032 Edge on bit 1 in the same clock as write 0x2 to address 3 -> edgecapture[1] remains 1.
REQ-033 EDGE_MODE=2, press and release bit 1 with mask 0 -> edgecapture=0x2, irq=0; write irqmask=0x2 -> irq=1 next clock.
REQ-034 Macro undefined: in_port[0] 1-clock low pulse -> edgecapture[0]=1 within 4 clocks; reset asserted mid-sequence -> all registers return to REQ-024 values.

Source files
------------

// File: rtl/finalsoc_key_irq.sv
// rtl/finalsoc_key_irq.sv - key input capture with edge interrupt, Avalon-MM slave
// Define FINALSOC_KEY_DEBOUNCE_EN to build per-bit debounce counters.
module finalsoc_key_irq #(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_MODE       = 1,
  parameter int IDLE_LEVEL      = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [WIDTH-1:0] IDLE = (IDLE_LEVEL != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

  logic [WIDTH-1:0] sync_q1, sync_q2;
  logic [WIDTH-1:0] stable, stable_d;
  logic [WIDTH-1:0] irqmask, edgecapture;
  logic [WIDTH-1:0] rise, fall, edge_hit, clr;
  logic             wr_en;
  logic             unused_ok;

  // Reset to the released level so leaving reset never looks like a key edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= IDLE;
      sync_q2 <= IDLE;
    end else begin
      sync_q1 <= in_port;
      sync_q2 <= sync_q1;
    end
  end

`ifdef FINALSOC_KEY_DEBOUNCE_EN
  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);
  logic [15:0] cnt [WIDTH];

  // Any return to the accepted level restarts the count, so short glitches are dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable <= IDLE;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_q2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= sync_q2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 16'd1;
        end
      end
    end
  end
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stable <= IDLE;
    else          stable <= sync_q2;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stable_d <= IDLE;
    else          stable_d <= stable;
  end

  assign rise = stable & ~stable_d;
  assign fall = ~stable & stable_d;

  always_comb begin
    edge_hit = fall;
    case (EDGE_MODE)
      0:       edge_hit = rise;
      1:       edge_hit = fall;
      default: edge_hit = rise | fall;
    endcase
  end

  assign wr_en = chipselect & ~write_n;
  assign clr   = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  // A new edge in the same clock as its clear keeps the bit set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask     <= '0;
      edgecapture <= '0;
      readdata    <= '0;
    end else begin
      if (wr_en && address == 2'd2) irqmask <= writedata[WIDTH-1:0];
      edgecapture <= (edgecapture & ~clr) | edge_hit;
      case (address)
        2'd0:    readdata <= 32'(stable);
        2'd2:    readdata <= 32'(irqmask);
        2'd3:    readdata <= 32'(edgecapture);
        default: readdata <= '0;
      endcase
    end
  end

  assign irq = |(edgecapture & irqmask);

  assign unused_ok = ^{writedata, 32'(DEBOUNCE_CYCLES)};

endmodule

// File: tb/tb_finalsoc_key_irq.sv
// tb/tb_finalsoc_key_irq.sv - self-checking bench for finalsoc_key_irq
module tb_finalsoc_key_irq;

`ifdef FINALSOC_KEY_DEBOUNCE_EN
  localparam int EDGE_LAT = 16 + 3;
`else
  localparam int EDGE_LAT = 4;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [1:0]  in_port, in_port2;
  logic [31:0] readdata, readdata2;
  logic        irq, irq2;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [1:0]  inp;
    int          idle;
    logic [1:0]  addr;
    bit          we;
    logic [31:0] wdata;
    bit          chk;
    logic [31:0] exp_rd;
    bit          exp_irq;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  finalsoc_key_irq #(.WIDTH(2), .DEBOUNCE_CYCLES(16), .EDGE_MODE(1), .IDLE_LEVEL(1)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  finalsoc_key_irq #(.WIDTH(2), .DEBOUNCE_CYCLES(16), .EDGE_MODE(2), .IDLE_LEVEL(1)) dut2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port2),
    .readdata(readdata2), .irq(irq2)
  );

  function automatic vec_t mk(input logic [1:0] inp, input int idle, input logic [1:0] addr,
                              input bit we, input logic [31:0] wdata, input bit chk,
                              input logic [31:0] exp_rd, input bit exp_irq);
    vec_t v;
    v.inp = inp; v.idle = idle; v.addr = addr; v.we = we; v.wdata = wdata;
    v.chk = chk; v.exp_rd = exp_rd; v.exp_irq = exp_irq;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    chipselect = 1'b0;
    write_n    = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus(input string name, input logic [1:0] addr, input bit we,
                     input logic [31:0] wdata, input bit chk, input logic [31:0] exp);
    address    = addr;
    chipselect = 1'b1;
    write_n    = !we;
    writedata  = wdata;
    if (chk) exp_q.push_back(exp);
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    if (chk) check(name, readdata, exp_q.pop_front());
  endtask

  initial begin
    reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = 2'b11; in_port2 = 2'b11;

    // inp, idle, addr, we, wdata, chk, exp_rd, exp_irq
    vecs.push_back(mk(2'b11,  2, 2'd0, 1'b0, 32'h0,  1'b1, 32'h3, 1'b0));
    vecs.push_back(mk(2'b11,  0, 2'd3, 1'b0, 32'h0,  1'b1, 32'h0, 1'b0));
    vecs.push_back(mk(2'b11,  0, 2'd2, 1'b0, 32'h0,  1'b1, 32'h0, 1'b0));
    vecs.push_back(mk(2'b11,  0, 2'd1, 1'b1, 32'hff, 1'b0, 32'h0, 1'b0));
    vecs.push_back(mk(2'b11,  0, 2'd1, 1'b0, 32'h0,  1'b1, 32'h0, 1'b0));
    vecs.push_back(mk(2'b11,  0, 2'd0, 1'b1, 32'h0,  1'b0, 32'h0, 1'b0));
    vecs.push_back(mk(2'b11,  0, 2'd0, 1'b0, 32'h0,  1'b1, 32'h3, 1'b0));
    vecs.push_back(mk(2'b11,  0, 2'd2, 1'b1, 32'h1,  1'b0, 32'h0, 1'b0));
    vecs.push_back(mk(2'b11,  0, 2'd2, 1'b0, 32'h0,  1'b1, 32'h1, 1'b0));
    vecs.push_back(mk(2'b10, 40, 2'd0, 1'b0, 32'h0,  1'b1, 32'h2, 1'b1));
    vecs.push_back(mk(2'b10,  0, 2'd3, 1'b0, 32'h0,  1'b1, 32'h1, 1'b1));
    vecs.push_back(mk(2'b10,  0, 2'd3, 1'b1, 32'h1,  1'b0, 32'h0, 1'b0));
    vecs.push_back(mk(2'b10,  0, 2'd3, 1'b0, 32'h0,  1'b1, 32'h0, 1'b0));
    vecs.push_back(mk(2'b11, 40, 2'd3, 1'b0, 32'h0,  1'b1, 32'h0, 1'b0));
    vecs.push_back(mk(2'b11,  0, 2'd0, 1'b0, 32'h0,  1'b1, 32'h3, 1'b0));
    vecs.push_back(mk(2'b11,  0, 2'd2, 1'b1, 32'h0,  1'b0, 32'h0, 1'b0));
    vecs.push_back(mk(2'b01, 40, 2'd3, 1'b0, 32'h0,  1'b1, 32'h2, 1'b0));
    vecs.push_back(mk(2'b01,  0, 2'd2, 1'b1, 32'h2,  1'b0, 32'h0, 1'b1));
    vecs.push_back(mk(2'b01,  0, 2'd3, 1'b1, 32'h2,  1'b0, 32'h0, 1'b0));
    vecs.push_back(mk(2'b11, 40, 2'd3, 1'b0, 32'h0,  1'b1, 32'h0, 1'b0));

    #23;
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    check("reset_readdata2", readdata2, 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      in_port = vecs[i].inp;
      idle(vecs[i].idle);
      bus($sformatf("vec%0d_rd", i), vecs[i].addr, vecs[i].we, vecs[i].wdata,
          vecs[i].chk, vecs[i].exp_rd);
      check($sformatf("vec%0d_irq", i), 32'(irq), 32'(vecs[i].exp_irq));
    end

    // Edge and write-1-clear on bit 1 land in the same clock: the bit stays set.
    in_port = 2'b01;
    idle(EDGE_LAT - 2);
    bus("setwin_pre", 2'd3, 1'b0, 32'h0, 1'b1, 32'h0);
    bus("setwin_wr", 2'd3, 1'b1, 32'h2, 1'b0, 32'h0);
    check("setwin_irq", 32'(irq), 32'h1);
    bus("setwin_rd", 2'd3, 1'b0, 32'h0, 1'b1, 32'h2);
    bus("setwin_clr", 2'd3, 1'b1, 32'h2, 1'b0, 32'h0);
    bus("setwin_after", 2'd3, 1'b0, 32'h0, 1'b1, 32'h0);
    check("setwin_irq_off", 32'(irq), 32'h0);
    in_port = 2'b11;
    idle(40);

`ifdef FINALSOC_KEY_DEBOUNCE_EN
    in_port = 2'b10;
    idle(10);
    in_port = 2'b11;
    idle(40);
    bus("glitch_data", 2'd0, 1'b0, 32'h0, 1'b1, 32'h3);
    bus("glitch_ec", 2'd3, 1'b0, 32'h0, 1'b1, 32'h0);
    in_port = 2'b10;
    idle(40);
    bus("held_data", 2'd0, 1'b0, 32'h0, 1'b1, 32'h2);
    bus("held_ec", 2'd3, 1'b0, 32'h0, 1'b1, 32'h1);
    check("held_irq", 32'(irq), 32'h0);
`else
    in_port = 2'b10;
    idle(1);
    in_port = 2'b11;
    idle(3);
    bus("pulse_ec", 2'd3, 1'b0, 32'h0, 1'b1, 32'h1);
    check("pulse_irq", 32'(irq), 32'h0);
`endif
    bus("pulse_clr", 2'd3, 1'b1, 32'h1, 1'b0, 32'h0);
    in_port = 2'b11;
    idle(40);
    bus("pulse_after", 2'd3, 1'b0, 32'h0, 1'b1, 32'h0);

    // Reset in the middle of activity.
    bus("mask3", 2'd2, 1'b1, 32'h3, 1'b0, 32'h0);
    in_port = 2'b01;
    idle(40);
    check("pre_rst_irq", 32'(irq), 32'h1);
    bus("pre_rst_mask", 2'd2, 1'b0, 32'h0, 1'b1, 32'h3);
`ifdef FINALSOC_KEY_DEBOUNCE_EN
    in_port = 2'b00;
    idle(10);
`else
    in_port = 2'b11;
    idle(2);
`endif
    #3;
    reset_n = 1'b0;
    #1;
    check("midrst_readdata", readdata, 32'h0);
    check("midrst_irq", 32'(irq), 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
`ifdef FINALSOC_KEY_DEBOUNCE_EN
    idle(12);
    bus("restart_data", 2'd0, 1'b0, 32'h0, 1'b1, 32'h3);
    idle(40);
    bus("restart_data2", 2'd0, 1'b0, 32'h0, 1'b1, 32'h0);
    bus("restart_ec", 2'd3, 1'b0, 32'h0, 1'b1, 32'h3);
`else
    idle(40);
    bus("postrst_data", 2'd0, 1'b0, 32'h0, 1'b1, 32'h3);
    bus("postrst_ec", 2'd3, 1'b0, 32'h0, 1'b1, 32'h0);
`endif
    bus("postrst_mask", 2'd2, 1'b0, 32'h0, 1'b1, 32'h0);
    check("postrst_irq", 32'(irq), 32'h0);
    bus("postrst_ec_clr", 2'd3, 1'b1, 32'h3, 1'b0, 32'h0);
    in_port = 2'b11;
    idle(40);

    // Either-edge instance: press and release of bit 1 are both captured.
    in_port2 = 2'b01;
    idle(40);
    bus("d2_press", 2'd3, 1'b0, 32'h0, 1'b0, 32'h0);
    check("d2_press_ec", readdata2, 32'h2);
    check("d2_press_irq", 32'(irq2), 32'h0);
    bus("d2_clr", 2'd3, 1'b1, 32'h2, 1'b0, 32'h0);
    in_port2 = 2'b11;
    idle(40);
    bus("d2_release", 2'd3, 1'b0, 32'h0, 1'b0, 32'h0);
    check("d2_release_ec", readdata2, 32'h2);
    check("d2_release_irq", 32'(irq2), 32'h0);
    bus("d2_mask", 2'd2, 1'b1, 32'h2, 1'b0, 32'h0);
    check("d2_unmask_irq", 32'(irq2), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
